// File: rtl/pong_pkg.sv
// Shared types and constants for the pong engine: FSM encoding, palette, paddle x offsets.
package pong_pkg;

  localparam int unsigned POS_W      = 10;
  localparam int unsigned RGB_W      = 12;
  localparam int unsigned SCORE_W    = 4;
  localparam int unsigned BALL_ROW_W = 3;
  localparam int unsigned BALL_ROM_W = 8;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [RGB_W-1:0] COL_PADDLE = 12'h080;
  localparam logic [RGB_W-1:0] COL_BALL   = 12'h008;
  localparam logic [RGB_W-1:0] COL_NET    = 12'h888;
  localparam logic [RGB_W-1:0] COL_BG     = 12'hFFF;
  localparam logic [RGB_W-1:0] COL_BLANK  = 12'h000;

  // Left paddle starts this many columns in; right paddle ends this many columns before H_ACTIVE.
  localparam int unsigned PADDLE_L_X   = 16;
  localparam int unsigned PADDLE_R_OFS = 17;

endpackage

// File: rtl/pong_ball_rom.sv
// Round 8x8 ball mask; one row of pixel enables per 3-bit row index.
module pong_ball_rom
  import pong_pkg::*;
(
  input  logic [BALL_ROW_W-1:0] row,
  output logic [BALL_ROM_W-1:0] row_data_c
);

  always_comb begin
    row_data_c = 8'hFF;
    case (row)
      3'd0:    row_data_c = 8'h3C;
      3'd1:    row_data_c = 8'h7E;
      3'd6:    row_data_c = 8'h7E;
      3'd7:    row_data_c = 8'h3C;
      default: row_data_c = 8'hFF;
    endcase
  end

endmodule

// File: rtl/pong_game_engine.sv
// Pong game engine: frame-tick driven ball/paddle physics, scoring FSM and registered pixel colour.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned PADDLE_H     = 72,
  parameter int unsigned PADDLE_W     = 4,
  parameter int unsigned PADDLE_STEP  = 4,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned BALL_SPEED   = 1,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_W-1:0]   pixel_x,
  input  logic [POS_W-1:0]   pixel_y,
  input  logic               video_on,
  input  logic [1:0]         btn_l,
  input  logic [1:0]         btn_r,
  input  logic               start,
  output logic [RGB_W-1:0]   rgb,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over
);

  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [POS_W-1:0]   BALL_X0     = POS_W'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0]   BALL_Y0     = POS_W'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0]   BALL_SZ     = POS_W'(BALL_SIZE);
  localparam logic [POS_W-1:0]   SPEED       = POS_W'(BALL_SPEED);
  localparam logic [POS_W-1:0]   PAD_H       = POS_W'(PADDLE_H);
  localparam logic [POS_W-1:0]   PAD_STEP    = POS_W'(PADDLE_STEP);
  localparam logic [POS_W-1:0]   PAD_TOP0    = POS_W'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [POS_W-1:0]   PAD_TOP_MIN = POS_W'(4);
  localparam logic [POS_W-1:0]   PAD_TOP_MAX = POS_W'(V_ACTIVE - 4 - PADDLE_H);
  localparam logic [POS_W-1:0]   L_COL_LO    = POS_W'(PADDLE_L_X);
  localparam logic [POS_W-1:0]   L_COL_HI    = POS_W'(PADDLE_L_X + PADDLE_W - 1);
  localparam logic [POS_W-1:0]   R_COL_HI    = POS_W'(H_ACTIVE - PADDLE_R_OFS);
  localparam logic [POS_W-1:0]   R_COL_LO    = POS_W'(H_ACTIVE - PADDLE_R_OFS - PADDLE_W + 1);
  localparam logic [POS_W-1:0]   Y_BOT_LIM   = POS_W'(V_ACTIVE - 1 - BALL_SPEED);
  localparam logic [POS_W-1:0]   X_RIGHT_LIM = POS_W'(H_ACTIVE - 1 - BALL_SPEED);
  localparam logic [POS_W-1:0]   NET_LO      = POS_W'(H_ACTIVE / 2 - 1);
  localparam logic [POS_W-1:0]   NET_HI      = POS_W'(H_ACTIVE / 2);
  localparam logic [POS_W-1:0]   TICK_Y      = POS_W'(V_ACTIVE + 1);
  localparam logic [SCORE_W-1:0] WIN         = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LAST  = CNT_W'(SERVE_FRAMES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   serve_cnt_q;
  logic [POS_W-1:0]   ball_x, ball_y, pad_l_q, pad_r_q;
  logic               dx_pos, dy_pos;
  logic               serve_dir_q, point_left_q, tick_hit_q;

  logic               tick_hit_c, tick_c;
  logic               y_ovl_l_c, y_ovl_r_c, hit_l_c, hit_r_c, edge_l_c, edge_r_c, miss_c;
  logic               dx_nxt_c, dy_nxt_c;
  logic [POS_W-1:0]   ball_right_c, x_nxt_c, y_nxt_c;
  logic [SCORE_W-1:0] score_inc_c;

  function automatic logic [POS_W-1:0] pad_next(input logic [POS_W-1:0] top,
                                                input logic [1:0]       btn);
    pad_next = top;
    case (btn)
      2'b01:   pad_next = (top >= PAD_TOP_MAX - PAD_STEP) ? PAD_TOP_MAX : top + PAD_STEP;
      2'b10:   pad_next = (top <= PAD_TOP_MIN + PAD_STEP) ? PAD_TOP_MIN : top - PAD_STEP;
      default: pad_next = top;
    endcase
  endfunction

  // Frame tick: rising edge of the (0, V_ACTIVE+1) match, so it is one cycle wide.
  assign tick_hit_c = (pixel_x == '0) && (pixel_y == TICK_Y);
  assign tick_c     = tick_hit_c && !tick_hit_q;

  // Bounce/miss evaluation on the current registered ball position.
  always_comb begin
    ball_right_c = ball_x + BALL_SZ - POS_W'(1);
    y_ovl_l_c    = (ball_y + BALL_SZ > pad_l_q) && (ball_y < pad_l_q + PAD_H);
    y_ovl_r_c    = (ball_y + BALL_SZ > pad_r_q) && (ball_y < pad_r_q + PAD_H);
    hit_l_c      = !dx_pos && (ball_x >= L_COL_LO) && (ball_x <= L_COL_HI) && y_ovl_l_c;
    hit_r_c      = dx_pos && (ball_right_c >= R_COL_LO) && (ball_right_c <= R_COL_HI) && y_ovl_r_c;
    edge_l_c     = (ball_x <= SPEED);
    edge_r_c     = (ball_x + BALL_SZ >= X_RIGHT_LIM);
    miss_c       = (edge_l_c || edge_r_c) && !(hit_l_c || hit_r_c);
    dx_nxt_c     = dx_pos;
    if (hit_l_c) dx_nxt_c = 1'b1;
    else if (hit_r_c) dx_nxt_c = 1'b0;
    dy_nxt_c     = dy_pos;
    if (ball_y <= SPEED) dy_nxt_c = 1'b1;
    else if (ball_y + BALL_SZ >= Y_BOT_LIM) dy_nxt_c = 1'b0;
    x_nxt_c      = dx_nxt_c ? ball_x + SPEED : ball_x - SPEED;
    y_nxt_c      = dy_nxt_c ? ball_y + SPEED : ball_y - SPEED;
    score_inc_c  = (point_left_q ? score_l : score_r) + SCORE_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SERVE: if (tick_c && serve_cnt_q == SERVE_LAST) state_d = ST_PLAY;
      ST_PLAY:  if (tick_c && miss_c) state_d = ST_POINT;
      ST_POINT: state_d = (score_inc_c == WIN) ? ST_OVER : ST_SERVE;
      ST_OVER:  if (start) state_d = ST_SERVE;
      default:  state_d = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_SERVE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_hit_q   <= 1'b0;
      serve_cnt_q  <= '0;
      ball_x       <= BALL_X0;
      ball_y       <= BALL_Y0;
      dx_pos       <= 1'b1;
      dy_pos       <= 1'b1;
      serve_dir_q  <= 1'b1;
      point_left_q <= 1'b0;
      pad_l_q      <= PAD_TOP0;
      pad_r_q      <= PAD_TOP0;
      score_l      <= '0;
      score_r      <= '0;
      game_over    <= 1'b0;
    end else begin
      tick_hit_q <= tick_hit_c;
      game_over  <= (state_d == ST_OVER);
      if (tick_c && state_q != ST_OVER) begin
        pad_l_q <= pad_next(pad_l_q, btn_l);
        pad_r_q <= pad_next(pad_r_q, btn_r);
      end
      case (state_q)
        ST_SERVE: begin
          if (tick_c) begin
            if (serve_cnt_q == SERVE_LAST) begin
              serve_cnt_q <= '0;
              dx_pos      <= serve_dir_q;
              dy_pos      <= 1'b1;
            end else begin
              serve_cnt_q <= serve_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (tick_c) begin
            if (miss_c) begin
              // The loser of this point receives the next serve.
              point_left_q <= edge_r_c;
              serve_dir_q  <= edge_r_c;
            end else begin
              ball_x <= x_nxt_c;
              ball_y <= y_nxt_c;
              dx_pos <= dx_nxt_c;
              dy_pos <= dy_nxt_c;
            end
          end
        end
        ST_POINT: begin
          if (point_left_q) score_l <= score_inc_c;
          else              score_r <= score_inc_c;
          if (score_inc_c != WIN) begin
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            serve_cnt_q <= '0;
          end
        end
        ST_OVER: begin
          if (start) begin
            score_l     <= '0;
            score_r     <= '0;
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            serve_cnt_q <= '0;
            serve_dir_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [BALL_ROM_W-1:0] rom_data_c;
  logic [POS_W-1:0]      dx_pix_c, dy_pix_c;
  logic                  in_ball_c, ball_px_c, paddle_px_c, net_px_c;

  assign dx_pix_c = pixel_x - ball_x;
  assign dy_pix_c = pixel_y - ball_y;

  pong_ball_rom u_ball_rom (
    .row        (BALL_ROW_W'(dy_pix_c)),
    .row_data_c (rom_data_c)
  );

  always_comb begin
    in_ball_c   = (pixel_x >= ball_x) && (pixel_x < ball_x + BALL_SZ) &&
                  (pixel_y >= ball_y) && (pixel_y < ball_y + BALL_SZ);
    ball_px_c   = in_ball_c && rom_data_c[BALL_ROW_W'(dx_pix_c)];
    paddle_px_c = ((pixel_x >= L_COL_LO) && (pixel_x <= L_COL_HI) &&
                   (pixel_y >= pad_l_q) && (pixel_y < pad_l_q + PAD_H)) ||
                  ((pixel_x >= R_COL_LO) && (pixel_x <= R_COL_HI) &&
                   (pixel_y >= pad_r_q) && (pixel_y < pad_r_q + PAD_H));
    net_px_c    = (pixel_x >= NET_LO) && (pixel_x <= NET_HI) && !pixel_y[4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rgb <= COL_BLANK;
    else if (!video_on)   rgb <= COL_BLANK;
    else if (paddle_px_c) rgb <= COL_PADDLE;
    else if (ball_px_c)   rgb <= COL_BALL;
    else if (net_px_c)    rgb <= COL_NET;
    else                  rgb <= COL_BG;
  end

endmodule
